// File: rtl/abrckt_autobaud.sv
// -----------------------------------------------------------------------------
// abrckt_autobaud
//   Auto-baud measurement block for the UART receive path. When armed by ABAUD
//   it times the 0x55 sync character on the RX line: it counts clock cycles
//   between the start-bit falling edge and the EDGES-th following falling edge
//   (each pair of bit times contains one falling edge), divides by 2*EDGES with
//   round-to-nearest, loads the result into the baud-rate generator, raises the
//   receive interrupt and asks the register file to clear ABAUD.
//
// Parameters
//   CNT_W  width of the measurement counter and of brg_val
//   EDGES  falling edges measured after the start edge (1, 2 or 4)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   abaud      auto-baud enable bit from UxMODE
//   uxrx       raw RX pin (asynchronous, idles high)
//   brg_val    measured bit period in clk cycles, rounded
//   brg_ld     1-cycle pulse: BRG loads brg_val
//   uxrxif     1-cycle receive-interrupt pulse on successful measurement
//   abaud_clr  1-cycle pulse: register file clears ABAUD
//   ab_busy    high while in ARM, WAIT_START or MEASURE
//   ab_ovf     1-cycle pulse when the measurement counter saturates
//
// Optional build macro
//   ABRCKT_GLITCH_FILTER_EN  when defined, the synchronised RX line is passed
//                            through a 3-sample majority filter so that
//                            single-cycle glitches produce no edge.
// -----------------------------------------------------------------------------
module abrckt_autobaud #(
    parameter int CNT_W = 16,
    parameter int EDGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abaud,
    input  logic             uxrx,
    output logic [CNT_W-1:0] brg_val,
    output logic             brg_ld,
    output logic             uxrxif,
    output logic             abaud_clr,
    output logic             ab_busy,
    output logic             ab_ovf
);

    localparam int SHIFT = $clog2(2 * EDGES);
    localparam int EW    = (EDGES > 1) ? $clog2(EDGES) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_START = 3'd2,
        MEASURE    = 3'd3,
        DONE       = 3'd4
    } state_t;

    // Round-to-nearest division of the measured span by 2*EDGES. The span is
    // counter+1 and may reach 2^CNT_W, so the arithmetic carries one extra bit.
    function automatic logic [CNT_W-1:0] round_period(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(1) + (CNT_W+1)'(EDGES);
        sum = sum >> SHIFT;
        return sum[CNT_W-1:0];
    endfunction

    logic             sync1_q;
    logic             sync2_q;
    logic             rx_prev_q;
    logic             rx_s;
    logic             fall_s;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [EW-1:0]    edge_q;
    logic [CNT_W-1:0] brg_val_q;
    logic             brg_ld_q;
    logic             uxrxif_q;
    logic             abaud_clr_q;
    logic             ab_busy_q;
    logic             ab_ovf_q;

    // Two-flop synchroniser for the asynchronous RX pin; resets to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uxrx;
            sync2_q <= sync1_q;
        end
    end

`ifdef ABRCKT_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // History of the two previous synchronised samples for the majority vote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    assign rx_s = majority3(sync2_q, hist1_q, hist2_q);
`else
    assign rx_s = sync2_q;
`endif

    // Previous line level, used to detect falling edges only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    assign fall_s = rx_prev_q & ~rx_s;

    // Measurement FSM with registered pulse and status outputs. Pulses are set
    // on the transition into DONE so they are high during the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_q      <= '0;
            brg_val_q   <= '0;
            brg_ld_q    <= 1'b0;
            uxrxif_q    <= 1'b0;
            abaud_clr_q <= 1'b0;
            ab_busy_q   <= 1'b0;
            ab_ovf_q    <= 1'b0;
        end else begin
            brg_ld_q    <= 1'b0;
            uxrxif_q    <= 1'b0;
            abaud_clr_q <= 1'b0;
            ab_ovf_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (abaud) begin
                        state_q   <= ARM;
                        ab_busy_q <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                        ab_busy_q <= 1'b0;
                    end
                end
                ARM: begin
                    cnt_q <= '0;
                    if (!abaud) begin
                        state_q   <= IDLE;
                        ab_busy_q <= 1'b0;
                    end else if (rx_s) begin
                        state_q   <= WAIT_START;
                        ab_busy_q <= 1'b1;
                    end else begin
                        state_q   <= ARM;
                        ab_busy_q <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (!abaud) begin
                        state_q   <= IDLE;
                        ab_busy_q <= 1'b0;
                    end else if (fall_s) begin
                        state_q   <= MEASURE;
                        cnt_q     <= '0;
                        edge_q    <= '0;
                        ab_busy_q <= 1'b1;
                    end else begin
                        state_q   <= WAIT_START;
                        ab_busy_q <= 1'b1;
                    end
                end
                MEASURE: begin
                    // Abort wins over a simultaneous final edge or overflow.
                    if (!abaud) begin
                        state_q   <= IDLE;
                        ab_busy_q <= 1'b0;
                    end else if (fall_s && (edge_q == EW'(EDGES - 1))) begin
                        state_q     <= DONE;
                        brg_val_q   <= round_period(cnt_q);
                        brg_ld_q    <= 1'b1;
                        uxrxif_q    <= 1'b1;
                        abaud_clr_q <= 1'b1;
                        ab_busy_q   <= 1'b0;
                    end else if (cnt_q == {CNT_W{1'b1}}) begin
                        state_q   <= ARM;
                        ab_ovf_q  <= 1'b1;
                        ab_busy_q <= 1'b1;
                    end else begin
                        state_q   <= MEASURE;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        edge_q    <= edge_q + EW'(fall_s);
                        ab_busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    ab_busy_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    ab_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign brg_val   = brg_val_q;
    assign brg_ld    = brg_ld_q;
    assign uxrxif    = uxrxif_q;
    assign abaud_clr = abaud_clr_q;
    assign ab_busy   = ab_busy_q;
    assign ab_ovf    = ab_ovf_q;

endmodule

// File: tb/tb_abrckt_autobaud.sv
module tb_abrckt_autobaud;

    logic        clk = 1'b0;
    logic        rst;
    logic        abaud;
    logic        uxrx;
    logic [15:0] brg_val;
    logic        brg_ld, uxrxif, abaud_clr, ab_busy, ab_ovf;

    logic        abaud8;
    logic        uxrx8;
    logic [7:0]  brg_val8;
    logic        brg_ld8, uxrxif8, abaud_clr8, ab_busy8, ab_ovf8;

    int tests = 0;
    int fails = 0;

    int n_ld = 0, n_if = 0, n_clr = 0, n_apart = 0;
    int n_ld8 = 0, n_ovf8 = 0, n_busy0_8 = 0;
    bit mon8_en = 1'b0;

    int ld0, if0, clr0;

    abrckt_autobaud #(.CNT_W(16), .EDGES(4)) dut (
        .clk(clk), .rst(rst), .abaud(abaud), .uxrx(uxrx),
        .brg_val(brg_val), .brg_ld(brg_ld), .uxrxif(uxrxif),
        .abaud_clr(abaud_clr), .ab_busy(ab_busy), .ab_ovf(ab_ovf)
    );

    abrckt_autobaud #(.CNT_W(8), .EDGES(4)) dut8 (
        .clk(clk), .rst(rst), .abaud(abaud8), .uxrx(uxrx8),
        .brg_val(brg_val8), .brg_ld(brg_ld8), .uxrxif(uxrxif8),
        .abaud_clr(abaud_clr8), .ab_busy(ab_busy8), .ab_ovf(ab_ovf8)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (brg_ld)    n_ld++;
        if (uxrxif)    n_if++;
        if (abaud_clr) n_clr++;
        if ((brg_ld | uxrxif | abaud_clr) && !(brg_ld & uxrxif & abaud_clr)) n_apart++;
        if (brg_ld8)   n_ld8++;
        if (ab_ovf8)   n_ovf8++;
        if (mon8_en && !ab_busy8) n_busy0_8++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        uxrx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0x55 in 8N1, LSB first: frame index i has level i[0] (start=0, stop=1).
    // Even frame indices last pa cycles, odd ones pb. gidx>=0 puts a 1-cycle
    // low glitch in the middle of that (high) frame bit.
    task automatic send55(input int pa, input int pb, input int gidx);
        int n;
        for (int i = 0; i < 10; i++) begin
            n = (i % 2 == 0) ? pa : pb;
            if (i == gidx) begin
                hold(1'b1, n / 2);
                hold(1'b0, 1);
                hold(1'b1, n - n / 2 - 1);
            end else begin
                hold(i[0], n);
            end
        end
        hold(1'b1, 10);
    endtask

    task automatic snap();
        ld0 = n_ld; if0 = n_if; clr0 = n_clr;
    endtask

    initial begin
        rst = 1'b0; abaud = 1'b0; uxrx = 1'b1;
        abaud8 = 1'b0; uxrx8 = 1'b1;
        #12;
        // Test 1: reset values.
        check("rst_brg_val", brg_val, 0);
        check("rst_brg_ld", brg_ld, 0);
        check("rst_uxrxif", uxrxif, 0);
        check("rst_abaud_clr", abaud_clr, 0);
        check("rst_ab_busy", ab_busy, 0);
        check("rst_ab_ovf", ab_ovf, 0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("idle_busy", ab_busy, 0);
        check("idle_no_ld", n_ld, 0);
        @(posedge clk); #1;

        // Test 2: 16 clk/bit -> meas 128 -> 16.
        snap();
        abaud = 1'b1;
        hold(1'b1, 5);
        send55(16, 16, -1);
        check("t2_brg_val", brg_val, 16);
        check("t2_ld_once", n_ld - ld0, 1);
        check("t2_if_once", n_if - if0, 1);
        check("t2_clr_once", n_clr - clr0, 1);
        check("t2_together", n_apart, 0);
        abaud = 1'b0;
        hold(1'b1, 5);

        // Test 5: abort in MEASURE keeps brg_val.
        snap();
        abaud = 1'b1;
        hold(1'b1, 5);
        hold(1'b0, 16);
        hold(1'b1, 16);
        @(negedge clk);
        check("t5_busy_before", ab_busy, 1);
        @(posedge clk); #1;
        abaud = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy_after", ab_busy, 0);
        hold(1'b0, 16);
        hold(1'b1, 40);
        check("t5_no_ld", n_ld - ld0, 0);
        check("t5_no_clr", n_clr - clr0, 0);
        check("t5_brg_kept", brg_val, 16);

        // Test 3a: 13 clk/bit -> meas 104 -> 13.
        snap();
        abaud = 1'b1;
        hold(1'b1, 5);
        send55(13, 13, -1);
        check("t3a_brg_val", brg_val, 13);
        check("t3a_ld_once", n_ld - ld0, 1);
        abaud = 1'b0;
        hold(1'b1, 5);

        // Test 3b: alternating 13/14 -> meas 108 -> 14.
        snap();
        abaud = 1'b1;
        hold(1'b1, 5);
        send55(13, 14, -1);
        check("t3b_brg_val", brg_val, 14);
        check("t3b_ld_once", n_ld - ld0, 1);
        abaud = 1'b0;
        hold(1'b1, 5);

        // Test 4: CNT_W=8, line stuck low -> one overflow, stays busy.
        abaud8 = 1'b1;
        repeat (5) @(posedge clk);
        #1; uxrx8 = 1'b0;
        repeat (2) @(posedge clk);
        #1; mon8_en = 1'b1;
        repeat (300) @(posedge clk);
        #1; mon8_en = 1'b0;
        check("t4_ovf_once", n_ovf8, 1);
        check("t4_no_ld", n_ld8, 0);
        check("t4_busy", ab_busy8, 1);
        check("t4_busy_never_low", n_busy0_8, 0);
        check("t4_brg_val", brg_val8, 0);
        abaud8 = 1'b0; uxrx8 = 1'b1;

        // Test 6: 1-cycle low glitch mid b0 at 16 clk/bit.
        snap();
        abaud = 1'b1;
        hold(1'b1, 5);
        send55(16, 16, 1);
        abaud = 1'b0;
        hold(1'b1, 5);
        check("t6_ld_once", n_ld - ld0, 1);
`ifdef ABRCKT_GLITCH_FILTER_EN
        check("t6_brg_filtered", brg_val, 16);
`else
        // Glitch edge at 24 counts: edges 24,32,64,96 -> meas 96 -> 12.
        check("t6_brg_unfiltered", brg_val, 12);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
